// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares one single-port data-memory BRAM between two requesters:
//   port 0 (load/store unit) and port 1 (debug/program loader).
//   Round-robin arbitration, byte/half/word decode to a lane-aligned word
//   access with byte write mask, and an RD_LAT-deep response pipeline that
//   returns lane-extracted read data in order.
//
// Parameters
//   RD_LAT        BRAM read latency in cycles (1..4)
// Ports
//   clk, rst      clock, asynchronous active-high reset
//   reqN/weN      request valid / store (1) or load (0)
//   addrN/wdataN  byte address / right-aligned store data
//   sizeN         00 byte, 01 half, 10 word, 11 illegal
//   gntN          request accepted this cycle (combinational)
//   rvalidN       one-cycle response pulse
//   rdataN/errN   load data (zero-extended) / misaligned-or-illegal flag
//   mem_we/mem_addr/mem_wd   BRAM write lanes, word address, shifted data
//   mem_rd        BRAM read word, RD_LAT cycles after its address
module dmem_arbiter #(
   parameter int RD_LAT = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0,
   input  logic        we0,
   input  logic [31:0] addr0,
   input  logic [31:0] wdata0,
   input  logic [1:0]  size0,
   input  logic        req1,
   input  logic        we1,
   input  logic [31:0] addr1,
   input  logic [31:0] wdata1,
   input  logic [1:0]  size1,
   output logic        gnt0,
   output logic        gnt1,
   output logic        rvalid0,
   output logic        rvalid1,
   output logic [31:0] rdata0,
   output logic [31:0] rdata1,
   output logic        err0,
   output logic        err1,
   output logic [3:0]  mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wd,
   input  logic [31:0] mem_rd
);

   typedef struct packed {
      logic       valid;
      logic       port;
      logic [1:0] off;
      logic [1:0] size;
      logic       err;
      logic       store;
   } rsp_ent_t;

   // last = port granted most recently (1 after reset so port 0 wins first)
   logic        last;
   logic        any_gnt;
   logic        sel;
   logic        s_we;
   logic [31:0] s_addr;
   logic [31:0] s_wdata;
   logic [1:0]  s_size;
   logic [1:0]  off;
   logic        bad;
   logic [3:0]  mask;

   rsp_ent_t    issue;
   rsp_ent_t    pipe [1:RD_LAT];
   rsp_ent_t    head;
   logic [31:0] lane;
   logic [31:0] ld_data;
   logic [31:0] rsp_data;

   // ---------------- arbitration ----------------
   always_comb begin
      gnt0 = req0 & (~req1 | last);
      gnt1 = req1 & (~req0 | ~last);
   end

   assign any_gnt = gnt0 | gnt1;
   assign sel     = gnt1;

   // ---------------- winner decode ----------------
   always_comb begin
      s_we    = sel ? we1    : we0;
      s_addr  = sel ? addr1  : addr0;
      s_wdata = sel ? wdata1 : wdata0;
      s_size  = sel ? size1  : size0;
      off     = s_addr[1:0];
   end

   always_comb begin
      bad  = 1'b0;
      mask = 4'b0000;
      case (s_size)
         2'b00: mask = 4'b0001 << off;
         2'b01: begin
            bad  = off[0];
            mask = 4'b0011 << off;
         end
         2'b10: begin
            bad  = |off;
            mask = 4'b1111;
         end
         default: bad = 1'b1;
      endcase
   end

   // Erroneous requests are still granted and tracked, but never write.
   always_comb begin
      mem_we   = (any_gnt & s_we & ~bad) ? mask : 4'b0000;
      mem_addr = any_gnt ? {s_addr[31:2], 2'b00} : 32'h0;
      mem_wd   = any_gnt ? (s_wdata << {off, 3'b000}) : 32'h0;
   end

   always_comb begin
      issue.valid = any_gnt;
      issue.port  = sel;
      issue.off   = off;
      issue.size  = s_size;
      issue.err   = bad;
      issue.store = s_we;
   end

   // ---------------- response pipeline ----------------
   // Stage k holds the access issued k cycles ago; stage RD_LAT lines up
   // with the BRAM read word for that access.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last <= 1'b1;
         for (int i = 1; i <= RD_LAT; i++) pipe[i] <= '0;
      end else begin
         if (any_gnt) last <= sel;
         pipe[1] <= issue;
         for (int i = 2; i <= RD_LAT; i++) pipe[i] <= pipe[i-1];
      end
   end

   assign head = pipe[RD_LAT];
   assign lane = mem_rd >> {head.off, 3'b000};

   always_comb begin
      case (head.size)
         2'b00:   ld_data = {24'h0, lane[7:0]};
         2'b01:   ld_data = {16'h0, lane[15:0]};
         default: ld_data = lane;
      endcase
      rsp_data = (head.valid & ~head.err & ~head.store) ? ld_data : 32'h0;
   end

   always_comb begin
      rvalid0 = head.valid & ~head.port;
      rvalid1 = head.valid &  head.port;
      err0    = rvalid0 & head.err;
      err1    = rvalid1 & head.err;
      rdata0  = head.port ? 32'h0 : rsp_data;
      rdata1  = head.port ? rsp_data : 32'h0;
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: two instances (RD_LAT=1 and RD_LAT=3) share the
// same stimulus, each with its own write-first BRAM model. Expected
// responses are pushed at grant time and popped when rvalid fires.
module tb_dmem_arbiter;

   logic        clk, rst;
   logic        req0, we0, req1, we1;
   logic [31:0] addr0, wdata0, addr1, wdata1;
   logic [1:0]  size0, size1;

   logic        gnt0_a, gnt1_a, rvalid0_a, rvalid1_a, err0_a, err1_a;
   logic [31:0] rdata0_a, rdata1_a, mem_addr_a, mem_wd_a, mem_rd_a;
   logic [3:0]  mem_we_a;
   logic        gnt0_b, gnt1_b, rvalid0_b, rvalid1_b, err0_b, err1_b;
   logic [31:0] rdata0_b, rdata1_b, mem_addr_b, mem_wd_b, mem_rd_b;
   logic [3:0]  mem_we_b;

   dmem_arbiter #(.RD_LAT(1)) u_a (
      .clk(clk), .rst(rst),
      .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .size0(size0),
      .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .size1(size1),
      .gnt0(gnt0_a), .gnt1(gnt1_a), .rvalid0(rvalid0_a), .rvalid1(rvalid1_a),
      .rdata0(rdata0_a), .rdata1(rdata1_a), .err0(err0_a), .err1(err1_a),
      .mem_we(mem_we_a), .mem_addr(mem_addr_a), .mem_wd(mem_wd_a), .mem_rd(mem_rd_a));

   dmem_arbiter #(.RD_LAT(3)) u_b (
      .clk(clk), .rst(rst),
      .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .size0(size0),
      .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .size1(size1),
      .gnt0(gnt0_b), .gnt1(gnt1_b), .rvalid0(rvalid0_b), .rvalid1(rvalid1_b),
      .rdata0(rdata0_b), .rdata1(rdata1_b), .err0(err0_b), .err1(err1_b),
      .mem_we(mem_we_b), .mem_addr(mem_addr_b), .mem_wd(mem_wd_b), .mem_rd(mem_rd_b));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   int cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                         input logic [3:0] be);
      logic [31:0] r;
      r = old;
      for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
      return r;
   endfunction

   function automatic logic [31:0] ext(input logic [31:0] w, input logic [1:0] off,
                                       input logic [1:0] s);
      int o;
      o = int'(off);
      case (s)
         2'd0:    return {24'h0, w[8*o +: 8]};
         2'd1:    return (o == 0) ? {16'h0, w[15:0]} : {16'h0, w[31:16]};
         2'd2:    return w;
         default: return 32'h0;
      endcase
   endfunction

   // ---------------- write-first BRAM models ----------------
   logic [31:0] mem_a [0:255];
   logic [31:0] mem_b [0:255];
   logic [31:0] refm  [0:255];
   logic [31:0] rda1, rdb1, rdb2, rdb3;

   always @(posedge clk) begin
      mem_a[mem_addr_a[9:2]] <= merge(mem_a[mem_addr_a[9:2]], mem_wd_a, mem_we_a);
      rda1 <= merge(mem_a[mem_addr_a[9:2]], mem_wd_a, mem_we_a);
      mem_b[mem_addr_b[9:2]] <= merge(mem_b[mem_addr_b[9:2]], mem_wd_b, mem_we_b);
      rdb1 <= merge(mem_b[mem_addr_b[9:2]], mem_wd_b, mem_we_b);
      rdb2 <= rdb1;
      rdb3 <= rdb2;
   end
   assign mem_rd_a = rda1;
   assign mem_rd_b = rdb3;

   // ---------------- scoreboard ----------------
   typedef struct {
      logic        port;
      logic [31:0] data;
      logic        err;
      int          due;
   } exp_t;

   exp_t qa[$];
   exp_t qb[$];
   exp_t ea, eb;
   logic mlast;
   logic obs_g0, obs_g1;

   always @(negedge clk) begin
      if (!rst && (rvalid0_a || rvalid1_a)) begin
         if (qa.size() == 0) chk("rv_a_spurious", {30'h0, rvalid1_a, rvalid0_a}, 32'h0);
         else begin
            ea = qa.pop_front();
            chk("rv_a_port", {30'h0, rvalid1_a, rvalid0_a}, ea.port ? 32'h2 : 32'h1);
            chk("rdata_a", ea.port ? rdata1_a : rdata0_a, ea.data);
            chk("err_a", {31'h0, ea.port ? err1_a : err0_a}, {31'h0, ea.err});
            chk("lat_a", 32'(cyc), 32'(ea.due));
         end
      end
      if (!rst && (rvalid0_b || rvalid1_b)) begin
         if (qb.size() == 0) chk("rv_b_spurious", {30'h0, rvalid1_b, rvalid0_b}, 32'h0);
         else begin
            eb = qb.pop_front();
            chk("rv_b_port", {30'h0, rvalid1_b, rvalid0_b}, eb.port ? 32'h2 : 32'h1);
            chk("rdata_b", eb.port ? rdata1_b : rdata0_b, eb.data);
            chk("err_b", {31'h0, eb.port ? err1_b : err0_b}, {31'h0, eb.err});
            chk("lat_b", 32'(cyc), 32'(eb.due));
         end
      end
   end

   // Drive one cycle of requests, check the issue side at the falling edge
   // against the bench's arbitration/decode model, and queue the response.
   task automatic step(input logic r0, input logic w0, input logic [31:0] a0,
                       input logic [31:0] d0, input logic [1:0] s0,
                       input logic r1, input logic w1, input logic [31:0] a1,
                       input logic [31:0] d1, input logic [1:0] s1);
      int          gp;
      logic        w, er;
      logic [31:0] a, d, ewd;
      logic [1:0]  s, off;
      logic [3:0]  ewe;
      exp_t        e;
      req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0; size0 = s0;
      req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1; size1 = s1;
      @(negedge clk);
      gp = -1;
      if (r0 && (!r1 || mlast)) gp = 0;
      else if (r1) gp = 1;
      obs_g0 = gnt0_a;
      obs_g1 = gnt1_a;
      chk("gnt0_a", {31'h0, gnt0_a}, {31'h0, gp == 0});
      chk("gnt1_a", {31'h0, gnt1_a}, {31'h0, gp == 1});
      chk("gnt0_b", {31'h0, gnt0_b}, {31'h0, gp == 0});
      chk("gnt1_b", {31'h0, gnt1_b}, {31'h0, gp == 1});
      if (gp >= 0) begin
         w = (gp == 1) ? w1 : w0;
         a = (gp == 1) ? a1 : a0;
         d = (gp == 1) ? d1 : d0;
         s = (gp == 1) ? s1 : s0;
         off = a[1:0];
         er = (s == 2'd3) || (s == 2'd1 && off[0]) || (s == 2'd2 && off != 2'd0);
         case (s)
            2'd0:    ewe = 4'b0001 << off;
            2'd1:    ewe = (off == 2'd0) ? 4'b0011 : 4'b1100;
            default: ewe = 4'b1111;
         endcase
         if (!w || er) ewe = 4'b0000;
         ewd = d << (8 * int'(off));
         chk("mem_we_a", {28'h0, mem_we_a}, {28'h0, ewe});
         chk("mem_we_b", {28'h0, mem_we_b}, {28'h0, ewe});
         chk("mem_addr_a", mem_addr_a, {a[31:2], 2'b00});
         chk("mem_addr_b", mem_addr_b, {a[31:2], 2'b00});
         if (ewe != 4'b0000) begin
            chk("mem_wd_a", mem_wd_a, ewd);
            chk("mem_wd_b", mem_wd_b, ewd);
         end
         e.port = gp[0];
         e.err  = er;
         e.data = (w || er) ? 32'h0 : ext(refm[a[9:2]], off, s);
         e.due  = cyc + 1;
         qa.push_back(e);
         e.due  = cyc + 3;
         qb.push_back(e);
         if (ewe != 4'b0000) refm[a[9:2]] = merge(refm[a[9:2]], ewd, ewe);
         mlast = gp[0];
      end else begin
         chk("idle_we_a", {28'h0, mem_we_a}, 32'h0);
         chk("idle_we_b", {28'h0, mem_we_b}, 32'h0);
         chk("idle_addr_a", mem_addr_a, 32'h0);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      logic        r0, w0, r1, w1;
      logic [31:0] a0, a1;
      logic [1:0]  s0, s1;
      for (int i = 0; i < 256; i++) begin
         refm[i]  = 32'h9E3779B9 * i + 32'h01234567;
         mem_a[i] = refm[i];
         mem_b[i] = refm[i];
      end
      refm[64] = 32'hAABBCCDD; mem_a[64] = 32'hAABBCCDD; mem_b[64] = 32'hAABBCCDD;
      refm[65] = 32'h11223344; mem_a[65] = 32'h11223344; mem_b[65] = 32'h11223344;
      mlast = 1'b1;
      rst = 1'b1;
      req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0; size0 = 0;
      req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0; size1 = 0;

      // reset state
      repeat (2) @(negedge clk);
      chk("rst_gnt", {28'h0, gnt0_a, gnt1_a, gnt0_b, gnt1_b}, 32'h0);
      chk("rst_rvalid", {28'h0, rvalid0_a, rvalid1_a, rvalid0_b, rvalid1_b}, 32'h0);
      chk("rst_err", {28'h0, err0_a, err1_a, err0_b, err1_b}, 32'h0);
      chk("rst_rdata_a", rdata0_a | rdata1_a, 32'h0);
      chk("rst_rdata_b", rdata0_b | rdata1_b, 32'h0);
      chk("rst_mem_we", {24'h0, mem_we_a, mem_we_b}, 32'h0);
      chk("rst_mem_addr", mem_addr_a | mem_addr_b, 32'h0);
      chk("rst_mem_wd", mem_wd_a | mem_wd_b, 32'h0);
      @(posedge clk); #1;
      rst = 1'b0;

      // contention from reset: grants alternate starting with port 0
      for (int i = 0; i < 6; i++) begin
         step(1, 0, 32'h100, 0, 2'd2, 1, 0, 32'h10B, 0, 2'd0);
         chk("cont_gnt0", {31'h0, obs_g0}, {31'h0, (i % 2) == 0});
         chk("cont_gnt1", {31'h0, obs_g1}, {31'h0, (i % 2) == 1});
      end
      idle(4);

      // single byte load at 0x103 -> 0xAA
      step(1, 0, 32'h103, 0, 2'd0, 0, 0, 0, 0, 0);
      chk("single_ld_exp", qa[qa.size()-1].data, 32'h000000AA);
      idle(4);

      // half store 0x1234 at 0x202, then load it back the next cycle
      step(0, 0, 0, 0, 0, 1, 1, 32'h202, 32'h00001234, 2'd1);
      step(0, 0, 0, 0, 0, 1, 0, 32'h202, 0, 2'd1);
      idle(4);

      // misaligned word store at 0x105: granted, no write, err response
      step(1, 1, 32'h105, 32'hDEADBEEF, 2'd2, 0, 0, 0, 0, 0);
      step(1, 0, 32'h104, 0, 2'd2, 0, 0, 0, 0, 0);
      idle(4);
      chk("mis_mem_a", mem_a[65], 32'h11223344);
      chk("mis_mem_b", mem_b[65], 32'h11223344);

      // illegal size, byte/half stores at various offsets
      step(0, 0, 0, 0, 0, 1, 0, 32'h108, 0, 2'd3);
      step(1, 1, 32'h109, 32'hFFFFFF5A, 2'd0, 0, 0, 0, 0, 0);
      step(1, 1, 32'h10E, 32'hFFFF9876, 2'd1, 0, 0, 0, 0, 0);
      step(1, 0, 32'h10C, 0, 2'd2, 0, 0, 0, 0, 0);
      step(1, 0, 32'h108, 0, 2'd2, 0, 0, 0, 0, 0);

      // latency sweep: back-to-back mixed loads
      step(1, 0, 32'h100, 0, 2'd0, 0, 0, 0, 0, 0);
      step(1, 0, 32'h102, 0, 2'd1, 0, 0, 0, 0, 0);
      step(1, 0, 32'h104, 0, 2'd2, 0, 0, 0, 0, 0);
      step(1, 0, 32'h101, 0, 2'd0, 0, 0, 0, 0, 0);
      step(1, 0, 32'h100, 0, 2'd1, 0, 0, 0, 0, 0);
      idle(5);

      // random mixed traffic
      for (int i = 0; i < 40; i++) begin
         r0 = 1'($urandom_range(0, 1)); w0 = 1'($urandom_range(0, 1));
         r1 = 1'($urandom_range(0, 1)); w1 = 1'($urandom_range(0, 1));
         a0 = 32'h100 + 32'($urandom_range(0, 63));
         a1 = 32'h100 + 32'($urandom_range(0, 63));
         s0 = 2'($urandom_range(0, 3)); s1 = 2'($urandom_range(0, 3));
         step(r0, w0, a0, $urandom, s0, r1, w1, a1, $urandom, s1);
      end
      idle(5);
      chk("drain_a", 32'(qa.size()), 32'h0);
      chk("drain_b", 32'(qa.size() + qb.size()), 32'h0);

      // reset mid-flight: port 1 then port 0 load, then reset
      step(0, 0, 0, 0, 0, 1, 0, 32'h100, 0, 2'd2);
      step(1, 0, 32'h104, 0, 2'd2, 0, 0, 0, 0, 0);
      rst = 1'b1;
      qa.delete();
      qb.delete();
      mlast = 1'b1;
      req0 = 0; req1 = 0;
      repeat (2) begin
         @(negedge clk);
         chk("rst_mid_rvalid", {28'h0, rvalid0_a, rvalid1_a, rvalid0_b, rvalid1_b}, 32'h0);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      idle(5);
      step(1, 0, 32'h100, 0, 2'd2, 1, 0, 32'h104, 0, 2'd2);
      chk("post_rst_gnt0", {31'h0, obs_g0}, 32'h1);
      idle(5);
      chk("final_drain", 32'(qa.size() + qb.size()), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
